// File: rtl/pwm_envelope_gen_if.sv
// Control and output bundle of the PWM envelope generator. Parameter N_CH must
// match the N_CH of the attached pwm_envelope_gen instance.
interface pwm_envelope_gen_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]   enable;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   pulse;
    logic              frame_tick;
    logic              env_tick;

    modport master (
        output enable, mode,
        input  pulse, frame_tick, env_tick
    );

    modport slave (
        input  enable, mode,
        output pulse, frame_tick, env_tick
    );
endinterface

// File: rtl/pwm_envelope_gen.sv
// Multi-channel PWM generator whose duty follows a square/ramp/triangle envelope.
// Define PWM_ENV_PHASE_EN to stagger the channel envelopes evenly in phase.
module pwm_envelope_gen #(
    parameter int CNT_W = 6,
    parameter int IDX_W = 6,
    parameter int N_CH  = 4
) (
    input logic               sysclk,
    input logic               rst_n,
    pwm_envelope_gen_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_SQUARE = 2'b00,
        MODE_RAMP   = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    localparam int EXT_W = (IDX_W > CNT_W) ? IDX_W : CNT_W;

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [N_CH-1:0]  r_pulse;
    logic             r_frame_tick;
    logic             r_env_tick;
    mode_e            r_mode_q [N_CH];
    logic [CNT_W:0]   r_duty_q [N_CH];

    logic             w_wrap;
    logic [IDX_W-1:0] w_idx_next;
    logic [IDX_W-1:0] w_ch_idx [N_CH];
    logic [CNT_W:0]   w_duty   [N_CH];

    // Bring a v_w-bit index onto the CNT_W-bit duty scale: zero-fill on the
    // right when narrower, keep only the top CNT_W bits when wider.
    function automatic logic [CNT_W-1:0] scale(input logic [IDX_W-1:0] v, input int v_w);
        logic [EXT_W-1:0] ext;
        ext = EXT_W'(v);
        if (v_w >= CNT_W) ext = ext >> (v_w - CNT_W);
        else              ext = ext << (CNT_W - v_w);
        return ext[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W:0] duty_of(input mode_e m, input logic [IDX_W-1:0] ix);
        logic [IDX_W-1:0] t;
        t = ix[IDX_W-1] ? {1'b0, ~ix[IDX_W-2:0]} : {1'b0, ix[IDX_W-2:0]};
        case (m)
            MODE_SQUARE: duty_of = ix[IDX_W-1] ? '0 : {1'b1, {CNT_W{1'b0}}};
            MODE_RAMP:   duty_of = {1'b0, scale(ix, IDX_W)};
            MODE_TRI:    duty_of = {1'b0, scale(t, IDX_W - 1)};
            default:     duty_of = '0;
        endcase
    endfunction

    assign w_wrap     = &r_cnt;
    assign w_idx_next = r_idx + IDX_W'(1);

    // Duties are derived from the index the coming period will run at.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
`ifdef PWM_ENV_PHASE_EN
        assign w_ch_idx[g] = w_idx_next + IDX_W'((g * (1 << IDX_W)) / N_CH);
`else
        assign w_ch_idx[g] = w_idx_next;
`endif
        assign w_duty[g] = duty_of(mode_e'(bus.mode[2*g +: 2]), w_ch_idx[g]);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pulse      <= '0;
            r_frame_tick <= 1'b0;
            r_env_tick   <= 1'b0;
            // NOTE: these per-channel arrays are ordinary flops, not RAM, so
            // they are cleared here; that is what silences the first period.
            for (int c = 0; c < N_CH; c++) begin
                r_mode_q[c] <= MODE_SQUARE;
                r_duty_q[c] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout so every register samples the
            // pre-edge r_cnt/r_idx regardless of statement order.
            r_cnt        <= r_cnt + CNT_W'(1);
            r_frame_tick <= w_wrap;
            r_env_tick   <= w_wrap & (&r_idx);
            if (w_wrap) begin
                r_idx <= w_idx_next;
                for (int c = 0; c < N_CH; c++) begin
                    r_mode_q[c] <= mode_e'(bus.mode[2*c +: 2]);
                    r_duty_q[c] <= w_duty[c];
                end
            end
            for (int c = 0; c < N_CH; c++) begin
                r_pulse[c] <= bus.enable[c] && (r_mode_q[c] != MODE_OFF) &&
                              ({1'b0, r_cnt} < r_duty_q[c]);
            end
        end
    end

    assign bus.pulse      = r_pulse;
    assign bus.frame_tick = r_frame_tick;
    assign bus.env_tick   = r_env_tick;
endmodule

// File: tb/tb_pwm_envelope_gen.sv
// Scoreboard bench for pwm_envelope_gen (CNT_W=6, IDX_W=6, N_CH=4): a behavioural
// model queues the expected outputs per edge, the negedge checker pops them.
module tb_pwm_envelope_gen;
    localparam int N_CH = 4;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;

    pwm_envelope_gen_if #(.N_CH(N_CH)) bus ();

    pwm_envelope_gen #(.CNT_W(6), .IDX_W(6), .N_CH(N_CH)) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model, written from the envelope equations in plain integers.
    int m_cnt, m_idx;
    int m_duty [N_CH];
    int m_mode [N_CH];
    logic [5:0] sb_q [$];

    function automatic int ref_duty(input int md, input int ix);
        case (md)
            0:       return (ix < 32) ? 64 : 0;
            1:       return ix;
            2:       return (ix < 32) ? 2 * ix : 2 * (63 - ix);
            default: return 0;
        endcase
    endfunction

    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_idx = 0;
            for (int c = 0; c < N_CH; c++) begin
                m_duty[c] = 0;
                m_mode[c] = 0;
            end
            sb_q.delete();
        end else begin
            logic [5:0] e;
            for (int c = 0; c < N_CH; c++)
                e[2+c] = bus.enable[c] && (m_mode[c] != 3) && (m_cnt < m_duty[c]);
            e[1] = (m_cnt == 63);
            e[0] = (m_cnt == 63) && (m_idx == 63);
            if (m_cnt == 63) begin
                m_idx = (m_idx + 1) % 64;
                for (int c = 0; c < N_CH; c++) begin
                    int ix;
`ifdef PWM_ENV_PHASE_EN
                    ix = (m_idx + c * 16) % 64;
`else
                    ix = m_idx;
`endif
                    m_mode[c] = int'(bus.mode[2*c +: 2]);
                    m_duty[c] = ref_duty(m_mode[c], ix);
                end
            end
            m_cnt = (m_cnt + 1) % 64;
            sb_q.push_back(e);
        end
    end

    always @(negedge sysclk) begin
        if (rst_n && sb_q.size() != 0) begin
            logic [5:0] e;
            e = sb_q.pop_front();
            check("sb_pulse", 32'(bus.pulse), 32'(e[5:2]));
            check("sb_frame_tick", 32'(bus.frame_tick), 32'(e[1]));
            check("sb_env_tick", 32'(bus.env_tick), 32'(e[0]));
        end
    end

    // Stops on the negedge where the model sits at (idx, cnt).
    task automatic wait_model(input int idx, input int cnt);
        for (int i = 0; i < 10000; i++) begin
            @(negedge sysclk);
            if (m_idx == idx && m_cnt == cnt) return;
        end
        check("wait_timeout", 32'(m_idx * 64 + m_cnt), 32'(idx * 64 + cnt));
    endtask

    // High-cycle count per channel over the whole period run at index idx.
    task automatic count_period(input int idx, output int hi [N_CH]);
        for (int c = 0; c < N_CH; c++) hi[c] = 0;
        wait_model(idx, 1);
        for (int k = 0; k < 64; k++) begin
            if (k != 0) @(negedge sysclk);
            for (int c = 0; c < N_CH; c++) hi[c] += int'(bus.pulse[c]);
        end
    endtask

    initial begin
        int hi [N_CH];
        int ticks;

        bus.enable = 4'b0111;
        bus.mode   = {2'b11, 2'b10, 2'b01, 2'b00};  // ch3 off, ch2 tri, ch1 ramp, ch0 square
        #12;
        check("rst_pulse", 32'(bus.pulse), 0);
        check("rst_frame_tick", 32'(bus.frame_tick), 0);
        check("rst_env_tick", 32'(bus.env_tick), 0);
        rst_n = 1'b1;

        count_period(0, hi);
        check("first_period_ch0", hi[0], 0);
        check("first_period_ch1", hi[1], 0);

        count_period(8, hi);
`ifndef PWM_ENV_PHASE_EN
        check("tri_idx8_ch2", hi[2], 16);
`endif
        count_period(16, hi);
`ifndef PWM_ENV_PHASE_EN
        check("ramp_idx16_ch1", hi[1], 16);
        check("square_idx16_ch0", hi[0], 64);
`endif
        count_period(40, hi);
`ifndef PWM_ENV_PHASE_EN
        check("tri_idx40_ch2", hi[2], 46);
        check("square_idx40_ch0", hi[0], 0);
`endif
        check("off_idx40_ch3", hi[3], 0);

        ticks = 0;
        for (int k = 0; k < 4096; k++) begin
            @(negedge sysclk);
            ticks += int'(bus.env_tick);
        end
        check("env_tick_per_envelope", ticks, 1);

        count_period(0, hi);
`ifndef PWM_ENV_PHASE_EN
        check("square_wrap_idx0_ch0", hi[0], 64);
`endif

        // Enable gating mid-period, acting on the very next edge.
        wait_model(1, 10);
        bus.enable[0] = 1'b0;
        @(negedge sysclk);
`ifndef PWM_ENV_PHASE_EN
        check("enable_drop_ch0", 32'(bus.pulse[0]), 0);
`endif
        bus.enable[0] = 1'b1;
        @(negedge sysclk);
`ifndef PWM_ENV_PHASE_EN
        check("enable_restore_ch0", 32'(bus.pulse[0]), 1);
`endif

        // Square -> off mid-period only takes effect at the next boundary.
        wait_model(5, 20);
        bus.mode[1:0] = 2'b11;
        count_period(6, hi);
        check("off_after_switch_ch0", hi[0], 0);

        // Asynchronous reset in the middle of a period clears outputs at once.
        wait_model(7, 30);
        bus.mode[1:0] = 2'b00;
        bus.enable    = 4'b1111;
        count_period(9, hi);
        @(negedge sysclk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pulse", 32'(bus.pulse), 0);
        check("async_rst_frame_tick", 32'(bus.frame_tick), 0);
        check("async_rst_env_tick", 32'(bus.env_tick), 0);
        @(negedge sysclk);
        #2 rst_n = 1'b1;
        count_period(0, hi);
        check("post_rst_first_period", hi[0] + hi[1] + hi[2] + hi[3], 0);
        count_period(1, hi);
        repeat (4) @(negedge sysclk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/pwm_envelope_gen.md
PWM_ENVELOPE_GEN -- requirements
Module: pwm_envelope_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 6, PWM period counter width; period = 2^CNT_W cycles.
REQ-002 SHALL have parameter IDX_W, default 6, envelope index width; envelope = 2^IDX_W periods; IDX_W >= 2.
REQ-003 SHALL have parameter N_CH, default 4, channel count; power of two, 1..16.
REQ-004 SHALL have port sysclk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, N_CH, per-channel output gate.
REQ-007 SHALL have port mode, input, 2*N_CH, per-channel mode, bits [2c+1:2c] = channel c: 00 square, 01 ramp, 10 triangle, 11 off.
REQ-008 SHALL have port pulse, output, N_CH, registered PWM outputs.
REQ-009 SHALL have port frame_tick, output, 1, registered one-cycle strobe per PWM period.
REQ-010 SHALL have port env_tick, output, 1, registered one-cycle strobe per envelope.

Function
REQ-011 SHALL free-run counter cnt (CNT_W bits): +1 every cycle, wraps from 2^CNT_W-1 to 0.
REQ-012 SHALL increment shared index idx (IDX_W bits) on the edge where cnt wraps; idx wraps modulo 2^IDX_W.
REQ-013 SHALL, on that same wrap edge, latch per-channel mode_q and duty_q (CNT_W+1 bits) computed from the new idx value; both constant for the whole period.
REQ-014 Square: duty = 2^CNT_W (100%) when idx < 2^(IDX_W-1), else 0.
REQ-015 Ramp: duty = idx scaled to CNT_W bits (left-shift zero-fill if IDX_W < CNT_W, keep top CNT_W bits if wider); max duty 2^CNT_W-1.
REQ-016 Triangle: t = idx[IDX_W-2:0] when idx MSB = 0, else bitwise inverse of idx[IDX_W-2:0]; duty = t scaled to CNT_W bits by REQ-015 rule.
REQ-017 Off: duty = 0.
REQ-018 SHALL register pulse[c] <= enable[c] AND (cnt < duty_q[c]); one-cycle latency from cnt to pin.
REQ-019 enable SHALL act on the next edge (not period-aligned); counter, idx and duty_q continue regardless of enable.
REQ-020 mode changes mid-period SHALL take effect only at the next period boundary.
REQ-021 frame_tick SHALL be 1 for exactly the cycle after the cnt wrap edge, i.e. frame_tick <= (cnt == 2^CNT_W-1).
REQ-022 env_tick SHALL be 1 for one cycle when cnt and idx wrap together, i.e. env_tick <= (cnt and idx both all-ones).

Reset
REQ-023 rst_n low SHALL immediately clear cnt, idx, mode_q, duty_q, pulse, frame_tick, env_tick to 0.
REQ-024 First period after reset release SHALL output pulse = 0 on all channels (duty_q = 0); enveloped output starts at idx = 1.
REQ-025 Reset asserted mid-period SHALL abandon the period; no partial state is retained.

Configuration
REQ-026 With macro PWM_ENV_PHASE_EN defined, channel c SHALL use index (idx + c*2^IDX_W/N_CH) mod 2^IDX_W for duty computation, giving equally staggered envelopes.
REQ-027 Without PWM_ENV_PHASE_EN, all channels SHALL use idx unmodified; no adder logic present.

Verification (CNT_W=6, IDX_W=6, N_CH=4, macro off unless stated)
REQ-028 Release reset, ch0 square, enable=0001 -> pulse[0] low period 0, high all 64 cycles for idx 1..31, low for idx 32..63, high again at idx 0 of next envelope; env_tick once per 4096 cycles.
REQ-029 ch1 ramp, enabled, period idx=16 -> pulse[1] high exactly 16 of 64 cycles, starting one cycle after frame_tick-aligned cnt=0.
REQ-030 ch2 triangle at idx=8 -> 16 high cycles; at idx=40 -> 46 high cycles.
REQ-031 Switch ch0 square->off at cnt=20 during idx=5 -> pulse[0] stays high to period end, low from next period.
REQ-032 Drop enable[0] at cnt=10 with 100% duty -> pulse[0] low from next cycle; re-assert -> high next cycle; frame_tick cadence unchanged.
REQ-033 PWM_ENV_PHASE_EN defined, all ramp, idx=0 period -> duties 0,16,32,48 on ch0..ch3; async rst_n pulse mid-period -> all outputs 0 same cycle.
